// File: rtl/ex_mem_skid_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ex_mem_skid_pkg                                            |
// | Purpose  : Shared widths, payload sizing and skid-buffer state type   |
// |            for the EX/MEM boundary register.                          |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package ex_mem_skid_pkg;

  // Default GPR address / data widths used across the pipeline.
  localparam int REG_ADDR_WIDTH_DEF = 5;
  localparam int REG_DATA_WIDTH_DEF = 32;

  // Occupancy of the two-entry skid buffer.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

  // Packed payload: {addr, data, reg_en, hi, lo, hilo_wen}.
  function automatic int payload_width(input int aw, input int dw);
    return aw + dw + 1 + dw + dw + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_mem_skid_pipe_skid_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pipe_skid_buf                                              |
// | Purpose  : Generic two-entry valid/ready buffer with flush. Entry M   |
// |            drives the output, entry S absorbs one beat of            |
// |            back-pressure so upstream never loses data.               |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module pipe_skid_buf
  import ex_mem_skid_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  skid_state_e      state_q, state_d;
  logic [WIDTH-1:0] m_data_q, m_data_d;
  logic [WIDTH-1:0] s_data_q, s_data_d;
  logic             accept;
  logic             pop;

  // Handshake signals; in_ready depends only on state, never on out_ready.
  always_comb begin
    in_ready  = (state_q != SKID_FULL);
    out_valid = (state_q != SKID_EMPTY);
    out_data  = m_data_q;
    accept    = in_valid & in_ready;
    pop       = out_valid & out_ready;
  end

  // Next-state and payload steering; S only ever feeds M, keeping FIFO order.
  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    s_data_d = s_data_q;
    case (state_q)
      SKID_EMPTY: begin
        if (accept) begin
          state_d  = SKID_ONE;
          m_data_d = in_data;
        end
      end
      SKID_ONE: begin
        if (accept && pop) begin
          m_data_d = in_data;
        end else if (accept) begin
          state_d  = SKID_FULL;
          s_data_d = in_data;
        end else if (pop) begin
          state_d  = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (pop) begin
          state_d  = SKID_ONE;
          m_data_d = s_data_q;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
    // Flush wins over everything; payload may go stale, validity cannot.
    if (flush) begin
      state_d = SKID_EMPTY;
    end
  end

  // State and payload registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SKID_EMPTY;
      m_data_q <= '0;
      s_data_q <= '0;
    end else begin
      state_q  <= state_d;
      m_data_q <= m_data_d;
      s_data_q <= s_data_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ex_mem_skid.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ex_mem_skid                                                |
// | Purpose  : EX/MEM boundary register with valid/ready handshake,       |
// |            one-entry skid, flush, optional HI/LO bundle and a         |
// |            saturating back-pressure cycle counter.                    |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module ex_mem_skid
  import ex_mem_skid_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
  parameter int REG_DATA_WIDTH = REG_DATA_WIDTH_DEF,
  parameter bit HILO_EN        = 1'b1,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [REG_ADDR_WIDTH-1:0] w_reg_addr_in,
  input  logic [REG_DATA_WIDTH-1:0] w_reg_data_in,
  input  logic                      w_reg_en_in,
  input  logic [REG_DATA_WIDTH-1:0] hi_regs_in,
  input  logic [REG_DATA_WIDTH-1:0] lo_regs_in,
  input  logic                      hilo_wen_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [REG_ADDR_WIDTH-1:0] w_reg_addr_out,
  output logic [REG_DATA_WIDTH-1:0] w_reg_data_out,
  output logic                      w_reg_en_out,
  output logic [REG_DATA_WIDTH-1:0] hi_regs_out,
  output logic [REG_DATA_WIDTH-1:0] lo_regs_out,
  output logic                      hilo_wen_out,
  output logic [CNT_WIDTH-1:0]      stall_cycles
);

  localparam int PAYLOAD_W = payload_width(REG_ADDR_WIDTH, REG_DATA_WIDTH);

  logic [PAYLOAD_W-1:0]      pl_in;
  logic [PAYLOAD_W-1:0]      pl_out;
  logic [REG_DATA_WIDTH-1:0] hi_pack;
  logic [REG_DATA_WIDTH-1:0] lo_pack;
  logic                      hilo_wen_pack;
  logic [REG_ADDR_WIDTH-1:0] m_addr;
  logic [REG_DATA_WIDTH-1:0] m_data;
  logic                      m_reg_en;
  logic [REG_DATA_WIDTH-1:0] m_hi;
  logic [REG_DATA_WIDTH-1:0] m_lo;
  logic                      m_hilo_wen;
  logic [CNT_WIDTH-1:0]      stall_q, stall_d;

  // HI/LO bundle is either carried through or tied off at both ends.
  generate
    if (HILO_EN) begin : g_hilo
      assign hi_pack       = hi_regs_in;
      assign lo_pack       = lo_regs_in;
      assign hilo_wen_pack = hilo_wen_in;
      assign hi_regs_out   = m_hi;
      assign lo_regs_out   = m_lo;
      assign hilo_wen_out  = out_valid & m_hilo_wen;
    end else begin : g_no_hilo
      logic unused_hilo;
      assign unused_hilo   = ^{hi_regs_in, lo_regs_in, hilo_wen_in, m_hi, m_lo, m_hilo_wen};
      assign hi_pack       = '0;
      assign lo_pack       = '0;
      assign hilo_wen_pack = 1'b0;
      assign hi_regs_out   = '0;
      assign lo_regs_out   = '0;
      assign hilo_wen_out  = 1'b0;
    end
  endgenerate

  // Pack incoming fields into one vector for the generic buffer.
  always_comb begin
    pl_in = {w_reg_addr_in, w_reg_data_in, w_reg_en_in, hi_pack, lo_pack, hilo_wen_pack};
  end

  pipe_skid_buf #(
    .WIDTH (PAYLOAD_W)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (pl_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (pl_out)
  );

  // Unpack entry M and gate the write enables with its validity.
  always_comb begin
    {m_addr, m_data, m_reg_en, m_hi, m_lo, m_hilo_wen} = pl_out;
    w_reg_addr_out = m_addr;
    w_reg_data_out = m_data;
    w_reg_en_out   = out_valid & m_reg_en;
  end

  // Stall counter next value: count MEM back-pressure, stop at all-ones.
  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != {CNT_WIDTH{1'b1}})) begin
      stall_d = stall_q + CNT_WIDTH'(1);
    end
    stall_cycles = stall_q;
  end

  // Stall counter register; only reset clears it, flush does not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_skid.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_ex_mem_skid                                             |
// | Purpose  : Directed self-checking bench for ex_mem_skid; a second     |
// |            instance covers HILO_EN=0 and a 4-bit stall counter.       |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_ex_mem_skid;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic [AW-1:0] addr_in;
  logic [DW-1:0] data_in;
  logic          en_in;
  logic [DW-1:0] hi_in;
  logic [DW-1:0] lo_in;
  logic          hwen_in;
  logic          out_ready;

  logic          in_ready,  in_ready2;
  logic          out_valid, out_valid2;
  logic [AW-1:0] addr_out,  addr_out2;
  logic [DW-1:0] data_out,  data_out2;
  logic          en_out,    en_out2;
  logic [DW-1:0] hi_out,    hi_out2;
  logic [DW-1:0] lo_out,    lo_out2;
  logic          hwen_out,  hwen_out2;
  logic [15:0]   stall;
  logic [3:0]    stall2;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  ex_mem_skid #(.REG_ADDR_WIDTH(AW), .REG_DATA_WIDTH(DW), .HILO_EN(1'b1), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .w_reg_addr_in(addr_in), .w_reg_data_in(data_in), .w_reg_en_in(en_in),
    .hi_regs_in(hi_in), .lo_regs_in(lo_in), .hilo_wen_in(hwen_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .w_reg_addr_out(addr_out), .w_reg_data_out(data_out), .w_reg_en_out(en_out),
    .hi_regs_out(hi_out), .lo_regs_out(lo_out), .hilo_wen_out(hwen_out),
    .stall_cycles(stall)
  );

  ex_mem_skid #(.REG_ADDR_WIDTH(AW), .REG_DATA_WIDTH(DW), .HILO_EN(1'b0), .CNT_WIDTH(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
    .w_reg_addr_in(addr_in), .w_reg_data_in(data_in), .w_reg_en_in(en_in),
    .hi_regs_in(hi_in), .lo_regs_in(lo_in), .hilo_wen_in(hwen_in),
    .out_valid(out_valid2), .out_ready(out_ready),
    .w_reg_addr_out(addr_out2), .w_reg_data_out(data_out2), .w_reg_en_out(en_out2),
    .hi_regs_out(hi_out2), .lo_regs_out(lo_out2), .hilo_wen_out(hwen_out2),
    .stall_cycles(stall2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic e);
    in_valid = v;
    addr_in  = a;
    data_in  = d;
    en_in    = e;
    hi_in    = '0;
    lo_in    = '0;
    hwen_in  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    #3;
    tests_run++;
    if ({out_valid, in_ready, addr_out, data_out, en_out, hi_out, lo_out, hwen_out} !== {1'b0, 1'b1, {AW{1'b0}}, {(3*DW+2){1'b0}}}) begin
      tests_failed++;
      $display("FAIL reset_outputs: out_valid=%b in_ready=%b addr=%h data=%h en=%b hi=%h lo=%h hwen=%b, required 0/1/0...",
               out_valid, in_ready, addr_out, data_out, en_out, hi_out, lo_out, hwen_out);
    end
    tests_run++;
    if (stall !== 16'd0 || stall2 !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_stall: got %0d/%0d, required 0/0", stall, stall2);
    end
    #19;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_stream();
    logic [DW-1:0] dv;
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      dv = DW'(i * 32'h11);
      drive(1'b1, AW'(i), dv, 1'b1);
      step();
      tests_run++;
      if (out_valid !== 1'b1 || addr_out !== AW'(i) || data_out !== dv || en_out !== 1'b1 || in_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL stream_%0d: valid=%b addr=%0d data=%h en=%b in_ready=%b, required 1/%0d/%h/1/1",
                 i, out_valid, addr_out, data_out, en_out, in_ready, i, dv);
      end
    end
    drive(1'b0, '0, '0, 1'b0);
    step();
    tests_run++;
    if (out_valid !== 1'b0 || en_out !== 1'b0 || stall !== 16'd0) begin
      tests_failed++;
      $display("FAIL stream_drain: valid=%b en=%b stall=%0d, required 0/0/0", out_valid, en_out, stall);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 5'd3, 32'hAAAA, 1'b1);
    step();
    tests_run++;
    if (out_valid !== 1'b1 || addr_out !== 5'd3 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_first: valid=%b addr=%0d in_ready=%b, required 1/3/1", out_valid, addr_out, in_ready);
    end
    drive(1'b1, 5'd4, 32'hBBBB, 1'b1);
    step();
    drive(1'b0, '0, '0, 1'b0);
    tests_run++;
    if (in_ready !== 1'b0 || addr_out !== 5'd3 || data_out !== 32'hAAAA) begin
      tests_failed++;
      $display("FAIL bp_full: in_ready=%b addr=%0d data=%h, required 0/3/0000aaaa", in_ready, addr_out, data_out);
    end
    repeat (3) step();
    tests_run++;
    if (stall !== 16'd4 || in_ready !== 1'b0 || data_out !== 32'hAAAA) begin
      tests_failed++;
      $display("FAIL bp_stall: stall=%0d in_ready=%b data=%h, required 4/0/0000aaaa", stall, in_ready, data_out);
    end
    out_ready = 1'b1;
    step();
    tests_run++;
    if (out_valid !== 1'b1 || addr_out !== 5'd4 || data_out !== 32'hBBBB || in_ready !== 1'b1 || stall !== 16'd4) begin
      tests_failed++;
      $display("FAIL bp_second: valid=%b addr=%0d data=%h in_ready=%b stall=%0d, required 1/4/0000bbbb/1/4",
               out_valid, addr_out, data_out, in_ready, stall);
    end
    step();
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_empty: valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 5'd5, 32'h5555, 1'b1);
    step();
    drive(1'b1, 5'd6, 32'h6666, 1'b1);
    step();
    drive(1'b1, 5'd7, 32'hCCCC, 1'b1);
    hwen_in = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    tests_run++;
    if (out_valid !== 1'b0 || en_out !== 1'b0 || hwen_out !== 1'b0 || in_ready !== 1'b1 || stall !== 16'd6) begin
      tests_failed++;
      $display("FAIL flush_full: valid=%b en=%b hwen=%b in_ready=%b stall=%0d, required 0/0/0/1/6",
               out_valid, en_out, hwen_out, in_ready, stall);
    end
    out_ready = 1'b1;
    step();
    tests_run++;
    if (out_valid !== 1'b0 || en_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_no_c: valid=%b en=%b addr=%0d, required 0/0", out_valid, en_out, addr_out);
    end
    drive(1'b1, 5'd8, 32'h8888, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    tests_run++;
    if (out_valid !== 1'b0 || en_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_accept: valid=%b en=%b, required 0/0", out_valid, en_out);
    end
  endtask

  task automatic test_hilo();
    out_ready = 1'b1;
    drive(1'b1, 5'd9, 32'h1234, 1'b0);
    hi_in = 32'hDEAD0000; lo_in = 32'h0000BEEF; hwen_in = 1'b1;
    step();
    drive(1'b0, '0, '0, 1'b0);
    tests_run++;
    if (out_valid !== 1'b1 || hwen_out !== 1'b1 || hi_out !== 32'hDEAD0000 || lo_out !== 32'h0000BEEF || en_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL hilo_on: valid=%b hwen=%b hi=%h lo=%h en=%b, required 1/1/dead0000/0000beef/0",
               out_valid, hwen_out, hi_out, lo_out, en_out);
    end
    tests_run++;
    if (out_valid2 !== 1'b1 || hwen_out2 !== 1'b0 || hi_out2 !== 32'd0 || lo_out2 !== 32'd0 || data_out2 !== 32'h1234) begin
      tests_failed++;
      $display("FAIL hilo_off: valid=%b hwen=%b hi=%h lo=%h data=%h, required 1/0/0/0/00001234",
               out_valid2, hwen_out2, hi_out2, lo_out2, data_out2);
    end
    step();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive(1'b1, 5'd10, 32'hA0A0, 1'b1);
    step();
    drive(1'b1, 5'd11, 32'hB0B0, 1'b1);
    step();
    drive(1'b0, '0, '0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || en_out !== 1'b0 || addr_out !== 5'd0 || data_out !== 32'd0 || in_ready !== 1'b1 ||
        stall !== 16'd0 || stall2 !== 4'd0) begin
      tests_failed++;
      $display("FAIL async_reset: valid=%b en=%b addr=%0d data=%h in_ready=%b stall=%0d/%0d, required 0/0/0/0/1/0/0",
               out_valid, en_out, addr_out, data_out, in_ready, stall, stall2);
    end
    #4;
    rst_n = 1'b1;
    step();
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL after_reset: valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_saturation();
    out_ready = 1'b0;
    drive(1'b1, 5'd12, 32'hC0C0, 1'b1);
    step();
    drive(1'b0, '0, '0, 1'b0);
    repeat (10) step();
    tests_run++;
    if (stall !== 16'd10 || stall2 !== 4'd10) begin
      tests_failed++;
      $display("FAIL sat_mid: stall=%0d stall4=%0d, required 10/10", stall, stall2);
    end
    repeat (10) step();
    tests_run++;
    if (stall !== 16'd20 || stall2 !== 4'd15) begin
      tests_failed++;
      $display("FAIL sat_end: stall=%0d stall4=%0d, required 20/15", stall, stall2);
    end
    out_ready = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_hilo();
    test_async_reset();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ex_mem_skid.md
Name: ex_mem_skid

Overview:
Parametrised EX/MEM pipeline boundary register that replaces the plain EX/MEM flop stage. It adds a valid/ready handshake, a one-entry skid buffer so back-pressure from MEM never drops an EX result, and a flush input for branch/exception squash. It carries the GPR write-back bundle and, optionally, the HI/LO write bundle. It also counts back-pressure cycles for performance monitoring.

Parameters:
REG_ADDR_WIDTH, 5, GPR write-address width
REG_DATA_WIDTH, 32, GPR and HI/LO data width
HILO_EN, 1, 1 = carry HI/LO bundle; 0 = HI/LO outputs tied 0 and inputs ignored
CNT_WIDTH, 16, width of saturating stall counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  squash all held and incoming entries
in_valid  in  1  EX presents a result
in_ready  out  1  stage can accept; transfer when in_valid&in_ready
w_reg_addr_in  in  REG_ADDR_WIDTH  GPR dest
w_reg_data_in  in  REG_DATA_WIDTH  GPR data
w_reg_en_in  in  1  GPR write enable
hi_regs_in  in  REG_DATA_WIDTH  HI data
lo_regs_in  in  REG_DATA_WIDTH  LO data
hilo_wen_in  in  1  HI/LO write enable
out_valid  out  1  entry presented to MEM
out_ready  in  1  MEM accepts; transfer when out_valid&out_ready
w_reg_addr_out  out  REG_ADDR_WIDTH  GPR dest
w_reg_data_out  out  REG_DATA_WIDTH  GPR data
w_reg_en_out  out  1  GPR write enable, qualified by out_valid
hi_regs_out  out  REG_DATA_WIDTH  HI data
lo_regs_out  out  REG_DATA_WIDTH  LO data
hilo_wen_out  out  1  HI/LO write enable, qualified by out_valid
stall_cycles  out  CNT_WIDTH  saturating count of cycles with out_valid&!out_ready

Behaviour:
- Reset (rst_n low, asynchronous): main and skid valid = 0; all payload flops = 0; stall_cycles = 0. While reset is low: out_valid=0, in_ready=1, and every data/enable output = 0.
- Storage: main entry M (drives outputs) plus skid entry S. in_ready = !S.valid. It is registered-derived and carries no combinational path from out_ready.
- States: EMPTY (M=0,S=0), ONE (M=1,S=0), FULL (M=1,S=1).
- EMPTY: accept -> ONE; the payload is visible at outputs the next cycle (latency 1).
- ONE: accept&pop -> ONE with the new payload; accept&!pop -> FULL, new payload into S; pop&!accept -> EMPTY; neither -> hold.
- FULL: in_ready=0, so there is no accept. Pop -> S moves to M, S cleared -> ONE. No pop -> hold.
- Order: strict FIFO; an entry in S never overtakes M.
- Flush (synchronous, highest priority over all events): M.valid and S.valid cleared next edge. Any input accepted in the flush cycle is discarded. A pop in the flush cycle still counts as completed by MEM. Payload flops may keep stale data, but the enables are masked.
- Output qualification: w_reg_en_out = M.valid & M.w_reg_en; hilo_wen_out = M.valid & M.hilo_wen (0 if HILO_EN=0). Data outputs show M payload whenever M.valid=1, else don't-care but stable.
- stall_cycles: +1 each cycle out_valid&!out_ready; saturates at all-ones with no wrap. Not cleared by flush.
- Throughput: with out_ready held high, one transfer per cycle sustained and FULL is never entered.
- Reset asserted mid-transfer: contents lost, outputs immediately 0; no partial writes reach MEM.

Decomposition:
- Shared package/defines: REG_ADDR_WIDTH/REG_DATA_WIDTH defaults (existing width macros), and the payload-bundle width constant (addr+data+en+hi+lo+hilo_wen) for pack/unpack.
- One natural sub-module: pipe_skid_buf. This is a generic width-parametrised 2-entry valid/ready buffer with flush, operating on a packed payload vector. ex_mem_skid packs/unpacks fields, applies output qualification, and owns the stall counter.

Test Plan:
- Reset then stream: out_ready=1, push addr 1..4 with data 0x11..0x44 on consecutive cycles -> out_valid a cycle later each, outputs in order, in_ready stays 1, stall_cycles=0.
- Back-pressure: push A(addr 3, data 0xAAAA) and B(addr 4, data 0xBBBB) with out_ready=0 -> in_ready drops to 0 after B. Hold 3 cycles -> stall_cycles=4. Raise out_ready -> A then B, no loss, in_ready returns 1.
- Flush while FULL, with in_valid=1 carrying C -> next cycle out_valid=0, w_reg_en_out=0, hilo_wen_out=0; C never appears.
- HI/LO path: push hilo_wen=1, hi=0xDEAD0000, lo=0x0000BEEF, w_reg_en=0 -> outputs match and w_reg_en_out=0. With HILO_EN=0 -> hilo_wen_out=0 and hi/lo outputs 0.
- Saturation: CNT_WIDTH=4, hold out_valid&!out_ready 20 cycles -> stall_cycles stops at 15.
- Async reset mid-FULL: drop rst_n between clock edges -> outputs 0 immediately, stall_cycles=0. After release the stage is EMPTY with in_ready=1.
